// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative divider among N_REQ requesters.
// Optional macro DIV_ARB_TIMEOUT_EN: abort WAIT after TIMEOUT cycles with rsp_err=1.
module div_arbiter #(
  parameter int N_REQ   = 4,
  parameter int L_DIVN  = 16,
  parameter int L_DIVR  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_vld,
  output logic [N_REQ-1:0]          req_rdy,
  input  logic [N_REQ*L_DIVN-1:0]   req_dividend,
  input  logic [N_REQ*L_DIVR-1:0]   req_divisor,
  output logic [N_REQ-1:0]          rsp_vld,
  input  logic [N_REQ-1:0]          rsp_rdy,
  output logic [L_DIVN-1:0]         rsp_quotient,
  output logic [L_DIVR-1:0]         rsp_remainder,
  output logic                      rsp_err,
  output logic                      div_start,
  output logic [L_DIVN-1:0]         div_dividend,
  output logic [L_DIVR-1:0]         div_divisor,
  input  logic                      div_ready,
  input  logic                      div_error,
  input  logic                      div_quotient_vld,
  input  logic [L_DIVN-1:0]         div_quotient,
  input  logic [L_DIVR-1:0]         div_remainder,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      timeout_flag
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CIW = IDW + 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("div_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state_q;
  logic [IDW-1:0]     rr_ptr_q;
  logic [IDW-1:0]     grant_id_q;
  logic               div_start_q;
  logic [L_DIVN-1:0]  div_dividend_q;
  logic [L_DIVR-1:0]  div_divisor_q;
  logic [N_REQ-1:0]   rsp_vld_q;
  logic [L_DIVN-1:0]  rsp_quot_q;
  logic [L_DIVR-1:0]  rsp_rem_q;
  logic               rsp_err_q;

  logic               gnt_found;
  logic [IDW-1:0]     gnt_idx;
  logic [CIW-1:0]     cand;
  logic               grant;
  logic [IDW-1:0]     rr_ptr_d;

  // Rotating priority search starting at rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + CIW'(k);
      if (cand >= CIW'(N_REQ)) cand = cand - CIW'(N_REQ);
      if (!gnt_found && req_vld[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
  end

  assign grant    = (state_q == S_IDLE) && div_ready && gnt_found;
  assign rr_ptr_d = (grant_id_q == IDW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    req_rdy = '0;
    if (grant) req_rdy[gnt_idx] = 1'b1;
  end

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          timeout_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      grant_id_q     <= '0;
      div_start_q    <= 1'b0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
      rsp_vld_q      <= '0;
      rsp_quot_q     <= '0;
      rsp_rem_q      <= '0;
      rsp_err_q      <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
      cnt_q          <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant) begin
            div_dividend_q <= req_dividend[gnt_idx*L_DIVN +: L_DIVN];
            div_divisor_q  <= req_divisor[gnt_idx*L_DIVR +: L_DIVR];
            grant_id_q     <= gnt_idx;
            div_start_q    <= 1'b1;
            state_q        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          div_start_q <= 1'b0;
          state_q     <= S_WAIT;
`ifdef DIV_ARB_TIMEOUT_EN
          cnt_q       <= '0;
`endif
        end
        S_WAIT: begin
          if (div_quotient_vld) begin
            rsp_quot_q <= div_quotient;
            rsp_rem_q  <= div_remainder;
            rsp_err_q  <= div_error;
            rsp_vld_q  <= ONE_HOT0 << grant_id_q;
            state_q    <= S_RESP;
          end
`ifdef DIV_ARB_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rsp_quot_q <= '0;
            rsp_rem_q  <= '0;
            rsp_err_q  <= 1'b1;
            rsp_vld_q  <= ONE_HOT0 << grant_id_q;
            timeout_q  <= 1'b1;
            state_q    <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_rdy[grant_id_q]) begin
            rsp_vld_q <= '0;
            rr_ptr_q  <= rr_ptr_d;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_vld       = rsp_vld_q;
  assign rsp_quotient  = rsp_quot_q;
  assign rsp_remainder = rsp_rem_q;
  assign rsp_err       = rsp_err_q;
  assign div_start     = div_start_q;
  assign div_dividend  = div_dividend_q;
  assign div_divisor   = div_divisor_q;
  assign busy          = (state_q != S_IDLE);
  assign grant_id      = grant_id_q;
`ifdef DIV_ARB_TIMEOUT_EN
  assign timeout_flag  = timeout_q;
`else
  assign timeout_flag  = 1'b0;
`endif

endmodule
